// File: rtl/pipelined_prefix_addsub.sv
// rtl/pipelined_prefix_addsub.sv - three-stage Brent-Kung add/subtract unit with saturation and valid/ready backpressure
module pipelined_prefix_addsub #(
    parameter int WIDTH      = 32,
    parameter int GROUP_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sat
);

    localparam int NG     = WIDTH / GROUP_SIZE;
    localparam int LOG_NG = $clog2(NG);

    logic adv1, adv2, adv3;
    logic v1_q, v2_q, v3_q;

    // stage 1: per-bit propagate/generate and per-group (G,P)
    logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
    logic [NG-1:0]    gg1_q, gg1_d, gp1_q, gp1_d;
    logic             cin1_q, sat1_q, amsb1_q;

    // stage 2: carry into every group; entry NG is the carry out of the MSB
    logic [WIDTH-1:0] p2_q, g2_q;
    logic [NG:0]      gc2_q, gc2_d;
    logic             sat2_q, amsb2_q;

    // stage 3: registered results
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, sat_q, sat_d;

    // Bubble-collapsing handshake: a stage moves when it is empty or its successor moves
    always_comb begin
        adv3     = !v3_q | out_ready;
        adv2     = !v2_q | adv3;
        adv1     = !v1_q | adv2;
        in_ready = adv1;
    end

    // Condition operand B and compute bit and group generate/propagate terms
    always_comb begin : s1_comb
        logic [WIDTH-1:0] bx;
        logic             c;
        logic             pp;
        bx    = sub ? ~b : b;
        p1_d  = a ^ bx;
        g1_d  = a & bx;
        gg1_d = '0;
        gp1_d = '0;
        c     = 1'b0;
        pp    = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c  = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < GROUP_SIZE; j++) begin
                c  = g1_d[k*GROUP_SIZE+j] | (p1_d[k*GROUP_SIZE+j] & c);
                pp = pp & p1_d[k*GROUP_SIZE+j];
            end
            gg1_d[k] = c;
            gp1_d[k] = pp;
        end
    end

    // Brent-Kung prefix over the groups, then fold in carry-in to get each group's carry
    always_comb begin : s2_comb
        logic [NG-1:0] ng;
        logic [NG-1:0] np;
        ng = gg1_q;
        np = gp1_q;
        for (int l = 0; l < LOG_NG; l++) begin
            for (int i = 0; i < NG; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    ng[i] = ng[i] | (np[i] & ng[i-(1<<l)]);
                    np[i] = np[i] & np[i-(1<<l)];
                end
            end
        end
        for (int l = LOG_NG - 2; l >= 0; l--) begin
            for (int i = 0; i < NG; i++) begin
                if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
                    ng[i] = ng[i] | (np[i] & ng[i-(1<<l)]);
                    np[i] = np[i] & np[i-(1<<l)];
                end
            end
        end
        gc2_d[0] = cin1_q;
        for (int k = 0; k < NG; k++) begin
            gc2_d[k+1] = ng[k] | (np[k] & cin1_q);
        end
    end

    // Ripple each group from its carry, derive flags and clamp on overflow when enabled
    always_comb begin : s3_comb
        logic [WIDTH-1:0] raw;
        logic             c;
        logic             c_msb;
        raw   = '0;
        c     = 1'b0;
        c_msb = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c = gc2_q[k];
            for (int j = 0; j < GROUP_SIZE; j++) begin
                raw[k*GROUP_SIZE+j] = p2_q[k*GROUP_SIZE+j] ^ c;
                if (k * GROUP_SIZE + j == WIDTH - 1) begin
                    c_msb = c;
                end
                c = g2_q[k*GROUP_SIZE+j] | (p2_q[k*GROUP_SIZE+j] & c);
            end
        end
        cout_d = gc2_q[NG];
        ovf_d  = c_msb ^ gc2_q[NG];
        sat_d  = ovf_d & sat2_q;
        // On overflow both effective operands share A's sign, so A's MSB picks the rail
        if (sat_d) begin
            sum_d = amsb2_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_d = raw;
        end
    end

    // Stage 1 register: accept a beat when stage 1 can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            p1_q    <= '0;
            g1_q    <= '0;
            gg1_q   <= '0;
            gp1_q   <= '0;
            cin1_q  <= 1'b0;
            sat1_q  <= 1'b0;
            amsb1_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                p1_q    <= p1_d;
                g1_q    <= g1_d;
                gg1_q   <= gg1_d;
                gp1_q   <= gp1_d;
                cin1_q  <= cin;
                sat1_q  <= sat_en;
                amsb1_q <= a[WIDTH-1];
            end
        end
    end

    // Stage 2 register: group carries plus forwarded bit terms
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            p2_q    <= '0;
            g2_q    <= '0;
            gc2_q   <= '0;
            sat2_q  <= 1'b0;
            amsb2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                p2_q    <= p1_q;
                g2_q    <= g1_q;
                gc2_q   <= gc2_d;
                sat2_q  <= sat1_q;
                amsb2_q <= amsb1_q;
            end
        end
    end

    // Stage 3 register: results only change when a new beat lands, so they hold while empty or stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// tb/tb_pipelined_prefix_addsub.sv - self-checking bench for pipelined_prefix_addsub
module tb_pipelined_prefix_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, sat_en;
    logic        out_valid, out_ready;
    logic        cout, ovf, sat;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_prefix_addsub #(.WIDTH(32), .GROUP_SIZE(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .sat(sat)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] es, input logic ec, input logic eo, input logic esat);
        check({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, "_sum"}, 128'(sum), 128'(es));
        check({tag, "_cout"}, 128'(cout), 128'(ec));
        check({tag, "_ovf"}, 128'(ovf), 128'(eo));
        check({tag, "_sat"}, 128'(sat), 128'(esat));
    endtask

    // Called at a negedge; sends one beat and checks its 3-cycle latency and result
    task automatic one_beat(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                            input logic tc, input logic ts, input logic tse,
                            input logic [31:0] es, input logic ec, input logic eo, input logic esat);
        in_valid = 1'b1; a = ta; b = tbv; cin = tc; sub = ts; sat_en = tse; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, 128'(in_ready), 128'(1'b1));
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1 check({tag, "_early"}, 128'(out_valid), 128'(1'b0));
        @(posedge clk); @(negedge clk);
        #1 chk_out(tag, es, ec, eo, esat);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Random streams on three width/group configurations against an arithmetic reference
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W  = (gi == 0) ? 32 : ((gi == 1) ? 16 : 64);
        localparam int GS = (gi == 0) ? 8 : ((gi == 1) ? 2 : 4);
        localparam int NB = 400;

        logic         rr, iv, ir, ov, orr, ci, sb, se, co, of, st, done;
        logic [W-1:0] ra, rb, rs;
        logic [W+2:0] q[$];

        pipelined_prefix_addsub #(.WIDTH(W), .GROUP_SIZE(GS)) u_rnd (
            .clk(clk), .rst(rr), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .sub(sb), .sat_en(se),
            .out_valid(ov), .out_ready(orr),
            .sum(rs), .cout(co), .ovf(of), .sat(st)
        );

        function automatic logic [W+2:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                   input logic c, input logic s, input logic e);
            logic [W-1:0]        yy;
            logic [W:0]          u;
            logic signed [W+1:0] sv, smax, smin;
            logic                o;
            logic [W-1:0]        r;
            yy   = s ? ~y : y;
            u    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
            sv   = $signed({{2{x[W-1]}}, x}) + $signed({{2{yy[W-1]}}, yy}) + $signed({{(W+1){1'b0}}, c});
            smax = {3'b000, {(W-1){1'b1}}};
            smin = {3'b111, {(W-1){1'b0}}};
            o    = (sv > smax) || (sv < smin);
            if (o && e) r = (sv > smax) ? smax[W-1:0] : smin[W-1:0];
            else        r = u[W-1:0];
            return {o && e, o, u[W], r};
        endfunction

        function automatic logic [W-1:0] rnd_op();
            logic [63:0] w;
            w = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(W-1){1'b0}}};
                3:       return {1'b0, {(W-1){1'b1}}};
                default: return W'(w);
            endcase
        endfunction

        initial begin
            int sent;
            int cyc;
            logic [W+2:0] e;
            done = 1'b0; rr = 1'b1; iv = 1'b0; orr = 1'b0;
            ra = '0; rb = '0; ci = 1'b0; sb = 1'b0; se = 1'b0;
            sent = 0; cyc = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rr = 1'b0;
            while ((sent < NB || q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                orr = ($urandom_range(0, 3) != 0);
                if (sent < NB && $urandom_range(0, 3) != 0) begin
                    iv = 1'b1; ra = rnd_op(); rb = rnd_op();
                    ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
                end else begin
                    iv = 1'b0;
                end
                #1;
                if (ov && orr) begin
                    check($sformatf("rnd%0d_qempty", gi), 128'(q.size() == 0), 128'(1'b0));
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check($sformatf("rnd%0d_result", gi), 128'({st, of, co, rs}), 128'(e));
                    end
                end
                if (iv && ir) begin
                    q.push_back(ref_model(ra, rb, ci, sb, se));
                    sent++;
                end
                cyc++;
            end
            check($sformatf("rnd%0d_sent", gi), 128'(sent), 128'(NB));
            check($sformatf("rnd%0d_drain", gi), 128'(q.size()), 128'(0));
            iv = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int occ;
        int idx;
        logic pop, push, all_done;
        logic [31:0] got[$];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_sum", 128'(sum), 128'(32'h0));
        check("rst_flags", 128'({cout, ovf, sat}), 128'(3'b000));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));

        one_beat("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        one_beat("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        one_beat("sub75", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0);
        one_beat("ovf_nosat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        one_beat("ovf_sat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        one_beat("neg_sat", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Backpressure: 5 beats, consumer stalled cycles 2..8; occupancy model predicts in_ready
        occ = 0; idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 8);
            if (idx < 5) begin
                in_valid = 1'b1; a = 32'(idx + 1); b = 32'h10; cin = 1'b0; sub = 1'b0; sat_en = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 128'(in_ready), 128'((occ < 3) || out_ready));
            if (out_valid && !out_ready) check("bp_hold", 128'(sum), 128'(32'h11));
            pop  = out_valid && out_ready;
            push = in_valid && in_ready;
            if (pop) got.push_back(sum);
            if (push) idx++;
            occ = occ + int'(push) - int'(pop);
            @(negedge clk);
        end
        check("bp_count", 128'(got.size()), 128'(5));
        for (int i = 0; i < got.size(); i++) check("bp_order", 128'(got[i]), 128'(32'h11 + i));
        idle(2);

        // Reset with three beats resident: none may ever emerge
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'hA00 + 32'(i); b = 32'h1; cin = 1'b0; sub = 1'b0; sat_en = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_out_valid", 128'(out_valid), 128'(1'b0));
        check("mrst_sum", 128'(sum), 128'(32'h0));
        check("mrst_flags", 128'({cout, ovf, sat}), 128'(3'b000));
        out_ready = 1'b1;
        in_valid = 1'b1; a = 32'h100; b = 32'h23;
        #1 check("mrst_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            #1;
            check("mrst_valid_seq", 128'(out_valid), 128'(n == 3));
            if (n == 3) check("mrst_sum_after", 128'(sum), 128'(32'h123));
            @(negedge clk);
        end

        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done;
        end
        check("rnd_all_done", 128'(all_done), 128'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
